// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and the
// hazard stall unit (slave): hazard sources in, register enables/flushes and statistics out.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_RS1;
    logic [4:0]       id_RS2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_ex_memread;
    logic [4:0]       id_ex_reg_RD;
    logic             ex_branch_taken;
    logic             ex_mem_memreq;
    logic             dmem_ready;
    logic             cnt_clr;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_RS1, id_RS2, id_uses_rs1, id_uses_rs2, id_ex_memread, id_ex_reg_RD,
               ex_branch_taken, ex_mem_memreq, dmem_ready, cnt_clr,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_bubble, mem_timeout,
               lu_stall_cnt, mem_wait_cnt, flush_cnt
    );

    modport slave (
        input  id_RS1, id_RS2, id_uses_rs1, id_uses_rs2, id_ex_memread, id_ex_reg_RD,
               ex_branch_taken, ex_mem_memreq, dmem_ready, cnt_clr,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_bubble, mem_timeout,
               lu_stall_cnt, mem_wait_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Resolves the hazards forwarding cannot: load-use stalls, taken-branch flushes and
// data-memory freezes, with a wait watchdog and saturating stall statistics.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_unit_if.slave  hz
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_TIMEOUT
    } state_t;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_FREEZE,
        SEL_BRANCH,
        SEL_LOAD_USE,
        SEL_NORMAL
    } outcome_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    outcome_t   sel;
    logic       freeze;
    logic       load_use;

    logic [CNT_W-1:0] lu_cnt_q, wait_cnt_q, flush_cnt_q;

    assign freeze   = hz.ex_mem_memreq & ~hz.dmem_ready;
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = hz.id_ex_memread & (hz.id_ex_reg_RD != 5'd0) &
                      (((hz.id_ex_reg_RD == hz.id_RS1) & hz.id_uses_rs1) |
                       ((hz.id_ex_reg_RD == hz.id_RS2) & hz.id_uses_rs2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (freeze) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            ST_WAIT: begin
                if (!freeze) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt    = ST_TIMEOUT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ST_TIMEOUT: state_nxt = ST_TIMEOUT;
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // A pending branch or load-use is held off during a freeze and acted on after release.
    always_comb begin
        sel = SEL_NORMAL;
        if (!rst_n)
            sel = SEL_RESET;
        else if ((state == ST_TIMEOUT) || freeze)
            sel = SEL_FREEZE;
        else if (hz.ex_branch_taken)
            sel = SEL_BRANCH;
        else if (load_use)
            sel = SEL_LOAD_USE;

        hz.pc_write      = 1'b1;
        hz.if_id_write   = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_write   = 1'b1;
        hz.id_ex_flush   = 1'b0;
        hz.ex_mem_write  = 1'b1;
        hz.mem_wb_bubble = 1'b0;

        case (sel)
            SEL_RESET: begin
                hz.pc_write      = 1'b0;
                hz.if_id_write   = 1'b0;
                hz.if_id_flush   = 1'b1;
                hz.id_ex_write   = 1'b0;
                hz.id_ex_flush   = 1'b1;
                hz.ex_mem_write  = 1'b0;
                hz.mem_wb_bubble = 1'b1;
            end
            SEL_FREEZE: begin
                hz.pc_write      = 1'b0;
                hz.if_id_write   = 1'b0;
                hz.id_ex_write   = 1'b0;
                hz.ex_mem_write  = 1'b0;
                hz.mem_wb_bubble = 1'b1;
            end
            SEL_BRANCH: begin
                hz.if_id_flush   = 1'b1;
                hz.id_ex_flush   = 1'b1;
            end
            SEL_LOAD_USE: begin
                hz.pc_write      = 1'b0;
                hz.if_id_write   = 1'b0;
                hz.id_ex_flush   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                              input logic             clr,
                                              input logic             evt);
        if (clr)
            return '0;
        else if (evt && (cnt != {CNT_W{1'b1}}))
            return cnt + 1'b1;
        else
            return cnt;
    endfunction

    // Clear beats a coincident increment; counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            lu_cnt_q    <= bump(lu_cnt_q,    hz.cnt_clr, sel == SEL_LOAD_USE);
            wait_cnt_q  <= bump(wait_cnt_q,  hz.cnt_clr, sel == SEL_FREEZE);
            flush_cnt_q <= bump(flush_cnt_q, hz.cnt_clr, sel == SEL_BRANCH);
        end
    end

    assign hz.mem_timeout  = (state == ST_TIMEOUT);
    assign hz.lu_stall_cnt = lu_cnt_q;
    assign hz.mem_wait_cnt = wait_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;

endmodule
